// File: rtl/stim_pkg.sv
// Shared types and constants for the stencil power stimulus block:
// FSM states, stimulus modes, LFSR tap constants and lane seed spreading.
package stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONFIG = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_LFSR    = 2'd0,
    MODE_RAMP    = 2'd1,
    MODE_FROZEN  = 2'd2,
    MODE_LFSR_EN = 2'd3
  } mode_t;

  localparam logic [7:0]  TAPS_8      = 8'hB8;
  localparam logic [15:0] TAPS_16     = 16'hB400;
  localparam logic [31:0] TAPS_32     = 32'h80200003;
  localparam logic [15:0] SEED_SPREAD = 16'h1F1F;

  // Galois tap mask for the supported lane widths (8, 16, 32).
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       return {24'h0, TAPS_8};
      16:      return {16'h0, TAPS_16};
      default: return TAPS_32;
    endcase
  endfunction

  // Lane seed before width adjustment: base XOR (lane * spread), kept to 16 bits.
  function automatic logic [31:0] lane_seed(input logic [15:0] base, input int unsigned lane);
    logic [15:0] w_spread;
    w_spread = 16'(lane * SEED_SPREAD);
    return {16'h0, base ^ w_spread};
  endfunction

endpackage

// File: rtl/stim_lfsr.sv
// One stimulus lane: Galois right-shift LFSR, ramp counter, or frozen value.
// load has priority over adv; the load value depends on the mode being loaded.
module stim_lfsr
  import stim_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              load,
  input  logic [DATA_W-1:0] seed,
  input  mode_t             mode,
  output logic [DATA_W-1:0] data
);

  localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_step;

  assign w_step = {1'b0, r_data[DATA_W-1:1]} ^ (r_data[0] ? TAPS : '0);
  assign data   = r_data;

  // Lane register: reload on start, otherwise advance according to mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= seed;
    end else if (load) begin
      r_data <= (mode == MODE_RAMP) ? '0 : seed;
    end else if (adv) begin
      case (mode)
        MODE_RAMP:   r_data <= r_data + DATA_W'(1);
        MODE_FROZEN: r_data <= r_data;
        default:     r_data <= w_step;
      endcase
    end
  end

endmodule

// File: rtl/stencil_power_stim.sv
// Stimulus generator and output monitor for power measurement of a stencil DUT.
// Optional feature macro: STIM_CHECKSUM_EN enables the output-data signature;
// without it the checksum output is tied to zero.
//
// state  | meaning
// IDLE   | waiting for the first start
// CONFIG | warm-up, lanes advance, no counting
// RUN    | measurement window, lanes advance, outputs counted
// DONE   | results held, waiting for next start
module stencil_power_stim
  import stim_pkg::*;
#(
  parameter int          NUM_IN        = 9,
  parameter int          NUM_OUT       = 8,
  parameter int          DATA_W        = 16,
  parameter int          CONFIG_CYCLES = 410,
  parameter int          RUN_CYCLES    = 1000,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [NUM_IN-1:0]         in_read_en,
  output logic [NUM_IN*DATA_W-1:0]  in_read_data,
  input  logic [NUM_OUT-1:0]        out_write_valid,
  input  logic [NUM_OUT*DATA_W-1:0] out_write_data,
  output logic                      window_active,
  output logic                      done,
  output logic [NUM_OUT*32-1:0]     out_count,
  output logic [31:0]               checksum
);

  state_t      r_state;
  mode_t       r_mode;
  logic [31:0] r_cnt;
  logic        r_window;
  logic        r_done;

  logic  w_accept;
  logic  w_active;
  mode_t w_mode_eff;

  assign w_accept      = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_active      = (r_state == ST_CONFIG) || (r_state == ST_RUN);
  assign w_mode_eff    = w_accept ? mode_t'(mode) : r_mode;
  assign window_active = r_window;
  assign done          = r_done;

  // Sequencer with terminal-count down-counter; window/done decoded alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_mode   <= MODE_LFSR;
      r_cnt    <= '0;
      r_window <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_mode <= mode_t'(mode);
            r_done <= 1'b0;
            if (CONFIG_CYCLES == 0) begin
              r_state  <= ST_RUN;
              r_cnt    <= 32'(RUN_CYCLES - 1);
              r_window <= 1'b1;
            end else begin
              r_state  <= ST_CONFIG;
              r_cnt    <= 32'(CONFIG_CYCLES - 1);
              r_window <= 1'b0;
            end
          end
        end
        ST_CONFIG: begin
          if (r_cnt == '0) begin
            r_state  <= ST_RUN;
            r_cnt    <= 32'(RUN_CYCLES - 1);
            r_window <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        ST_RUN: begin
          if (r_cnt == '0) begin
            r_state  <= ST_DONE;
            r_window <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_window <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lane
    localparam logic [DATA_W-1:0] SEED_T    = DATA_W'(lane_seed(SEED, gi));
    localparam logic [DATA_W-1:0] LANE_SEED = (SEED_T == '0) ? DATA_W'(1) : SEED_T;

    logic w_adv;
    // Free-running LFSR ignores the read enable; other modes step on it.
    assign w_adv = w_active && (r_mode == MODE_LFSR || in_read_en[gi]);

    stim_lfsr #(.DATA_W(DATA_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (w_adv),
      .load  (w_accept),
      .seed  (LANE_SEED),
      .mode  (w_mode_eff),
      .data  (in_read_data[gi*DATA_W +: DATA_W])
    );
  end

  for (genvar gj = 0; gj < NUM_OUT; gj++) begin : g_count
    logic [31:0] r_count;
    // Saturating count of valid beats seen inside the measurement window.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_count <= '0;
      end else if (w_accept) begin
        r_count <= '0;
      end else if (r_state == ST_RUN && out_write_valid[gj] && r_count != '1) begin
        r_count <= r_count + 32'd1;
      end
    end
    assign out_count[gj*32 +: 32] = r_count;
  end

`ifdef STIM_CHECKSUM_EN
  logic [31:0] r_checksum;
  logic [31:0] w_beat_xor;

  // Fold all valid lanes of this cycle into one word.
  always_comb begin
    w_beat_xor = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      if (out_write_valid[j]) w_beat_xor = w_beat_xor ^ 32'(out_write_data[j*DATA_W +: DATA_W]);
    end
  end

  // Rotate-and-xor signature, accumulated only during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= '0;
    end else if (r_state == ST_RUN) begin
      r_checksum <= {r_checksum[30:0], r_checksum[31]} ^ w_beat_xor;
    end
  end

  assign checksum = r_checksum;
`else
  logic w_unused_data;
  assign w_unused_data = ^out_write_data;
  assign checksum      = '0;
`endif

endmodule

// File: tb/tb_stencil_power_stim.sv
// Directed bench for stencil_power_stim (DATA_W=16, CONFIG=4, RUN=8, SEED=1).
module tb_stencil_power_stim;

  localparam int NI = 9;
  localparam int NO = 8;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic [NI-1:0]   in_read_en = '0;
  logic [NI*DW-1:0] in_read_data;
  logic [NO-1:0]   out_write_valid = '0;
  logic [NO*DW-1:0] out_write_data = '0;
  logic            window_active;
  logic            done;
  logic [NO*32-1:0] out_count;
  logic [31:0]     checksum;

  int n_pass = 0;
  int n_total = 0;

  stencil_power_stim #(
    .NUM_IN(NI), .NUM_OUT(NO), .DATA_W(DW),
    .CONFIG_CYCLES(4), .RUN_CYCLES(8), .SEED(16'h0001)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .in_read_en(in_read_en), .in_read_data(in_read_data),
    .out_write_valid(out_write_valid), .out_write_data(out_write_data),
    .window_active(window_active), .done(done),
    .out_count(out_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [15:0] lane(input int i);
    return in_read_data[i*DW +: DW];
  endfunction

  function automatic logic [31:0] cnt(input int j);
    return out_count[j*32 +: 32];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Edge 0 is the tick before start is driven; returns just after edge 1.
  task automatic launch(input logic [1:0] m);
    tick;
    start = 1'b1;
    mode  = m;
    tick;
    start = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_total++; if (window_active !== 1'b0) $display("FAIL rst_window got %0b want 0", window_active); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done got %0b want 0", done); else n_pass++;
    n_total++; if (out_count !== '0) $display("FAIL rst_count got %h want 0", out_count); else n_pass++;
    n_total++; if (checksum !== 32'h0) $display("FAIL rst_checksum got %h want 0", checksum); else n_pass++;
    n_total++; if (lane(0) !== 16'h0001) $display("FAIL rst_seed0 got %h want 0001", lane(0)); else n_pass++;
    n_total++; if (lane(1) !== 16'h1F1E) $display("FAIL rst_seed1 got %h want 1f1e", lane(1)); else n_pass++;
    n_total++; if (lane(8) !== 16'hF8F9) $display("FAIL rst_seed8 got %h want f8f9", lane(8)); else n_pass++;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_window_lfsr;
    logic [15:0] m;
    m = 16'h0001;
    launch(2'd0);
    for (int e = 1; e <= 16; e++) begin
      if (e > 1) tick;
      if (e >= 2 && e <= 13) m = lstep(m);
      n_total++; if (window_active !== (e >= 5 && e <= 12)) $display("FAIL win_e%0d got %0b want %0b", e, window_active, (e >= 5 && e <= 12)); else n_pass++;
      n_total++; if (done !== (e >= 13)) $display("FAIL done_e%0d got %0b want %0b", e, done, (e >= 13)); else n_pass++;
      n_total++; if (lane(0) !== m) $display("FAIL lfsr_e%0d got %h want %h", e, lane(0), m); else n_pass++;
    end
  endtask

  task automatic test_counts_checksum;
    logic [31:0] cks_exp;
`ifdef STIM_CHECKSUM_EN
    cks_exp = 32'h6;
`else
    cks_exp = 32'h0;
`endif
    out_write_valid = 8'b0000_0011;
    launch(2'd0);
    for (int e = 1; e <= 18; e++) begin
      if (e > 1) tick;
      start = (e == 2 || e == 8);
      if (e == 11) out_write_data[15:0] = 16'h0001;
      else if (e == 12) out_write_data[15:0] = 16'h0004;
      else out_write_data[15:0] = 16'h0000;
      if (e == 12) begin
        n_total++; if (window_active !== 1'b1) $display("FAIL ign_win got %0b want 1", window_active); else n_pass++;
      end
      if (e == 13) begin
        n_total++; if (done !== 1'b1) $display("FAIL ign_done got %0b want 1", done); else n_pass++;
      end
    end
    start = 1'b0;
    n_total++; if (cnt(0) !== 32'd8) $display("FAIL count0 got %0d want 8", cnt(0)); else n_pass++;
    n_total++; if (cnt(1) !== 32'd8) $display("FAIL count1 got %0d want 8", cnt(1)); else n_pass++;
    n_total++; if (out_count[NO*32-1:64] !== '0) $display("FAIL count_rest got %h want 0", out_count[NO*32-1:64]); else n_pass++;
    n_total++; if (checksum !== cks_exp) $display("FAIL checksum got %h want %h", checksum, cks_exp); else n_pass++;
    out_write_valid = '0;
  endtask

  task automatic test_ramp;
    launch(2'd1);
    n_total++; if (out_count !== '0) $display("FAIL ramp_cnt_clr got %h want 0", out_count); else n_pass++;
    n_total++; if (checksum !== 32'h0) $display("FAIL ramp_cks_clr got %h want 0", checksum); else n_pass++;
    n_total++; if (lane(0) !== 16'h0) $display("FAIL ramp_e1 got %h want 0", lane(0)); else n_pass++;
    in_read_en[0] = 1'b1;
    for (int e = 2; e <= 14; e++) begin
      tick;
      if (e == 4) in_read_en[0] = 1'b0;
      if (e <= 8) begin
        n_total++; if (lane(0) !== 16'((e <= 4) ? e - 1 : 3)) $display("FAIL ramp_e%0d got %h want %h", e, lane(0), 16'((e <= 4) ? e - 1 : 3)); else n_pass++;
      end
    end
    n_total++; if (lane(1) !== 16'h0) $display("FAIL ramp_lane1 got %h want 0", lane(1)); else n_pass++;
  endtask

  task automatic test_gated_frozen;
    logic [15:0] g;
    g = lstep(lstep(16'h3E3F));
    launch(2'd3);
    in_read_en[2] = 1'b1;
    for (int e = 2; e <= 14; e++) begin
      tick;
      if (e == 3) in_read_en[2] = 1'b0;
    end
    n_total++; if (lane(2) !== g) $display("FAIL gated_lane2 got %h want %h", lane(2), g); else n_pass++;
    n_total++; if (lane(0) !== 16'h0001) $display("FAIL gated_lane0 got %h want 0001", lane(0)); else n_pass++;
    launch(2'd2);
    in_read_en = '1;
    for (int e = 2; e <= 14; e++) tick;
    in_read_en = '0;
    n_total++; if (lane(0) !== 16'h0001) $display("FAIL frozen_lane0 got %h want 0001", lane(0)); else n_pass++;
    n_total++; if (lane(2) !== 16'h3E3F) $display("FAIL frozen_lane2 got %h want 3e3f", lane(2)); else n_pass++;
  endtask

  task automatic test_reset_mid_run;
    logic [15:0] m;
    logic [31:0] cks_exp;
`ifdef STIM_CHECKSUM_EN
    cks_exp = 32'h5;
`else
    cks_exp = 32'h0;
`endif
    out_write_valid = 8'b0000_0011;
    out_write_data[15:0] = 16'h0003;
    launch(2'd0);
    for (int e = 2; e <= 7; e++) tick;
    n_total++; if (cnt(0) !== 32'd2) $display("FAIL mid_count got %0d want 2", cnt(0)); else n_pass++;
    n_total++; if (checksum !== cks_exp) $display("FAIL mid_cks got %h want %h", checksum, cks_exp); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (window_active !== 1'b0) $display("FAIL mrst_window got %0b want 0", window_active); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL mrst_done got %0b want 0", done); else n_pass++;
    n_total++; if (out_count !== '0) $display("FAIL mrst_count got %h want 0", out_count); else n_pass++;
    n_total++; if (checksum !== 32'h0) $display("FAIL mrst_cks got %h want 0", checksum); else n_pass++;
    n_total++; if (lane(0) !== 16'h0001) $display("FAIL mrst_seed got %h want 0001", lane(0)); else n_pass++;
    #2 rst_n = 1'b1;
    out_write_valid = '0;
    out_write_data = '0;
    m = 16'h0001;
    launch(2'd0);
    for (int e = 1; e <= 6; e++) begin
      if (e > 1) tick;
      if (e >= 2) m = lstep(m);
      n_total++; if (lane(0) !== m) $display("FAIL replay_e%0d got %h want %h", e, lane(0), m); else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_window_lfsr;
    test_counts_checksum;
    test_ramp;
    test_gated_frozen;
    test_reset_mid_run;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
